// File: rtl/fp_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// floatingpointpkg
// Shared types and constants for the single-precision adder control path.
//   fp_add_state_t : sequencer states
//   norm_ctrl_t    : normaliser / exponent-adjust control bundle
//   SAT_SHIFT      : alignment shift saturation (larger shifts go to sticky)
//   MANT_MSB       : find-first-one index of a normalised hidden bit
// ---------------------------------------------------------------------------
package floatingpointpkg;

    localparam int SAT_SHIFT = 26;
    localparam int MANT_MSB  = 23;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        NORM   = 3'd2,
        ROUND  = 3'd3,
        RENORM = 3'd4,
        DONE   = 3'd5
    } fp_add_state_t;

    typedef struct packed {
        logic       SREn;
        logic       SLEn;
        logic       NoShift;
        logic       IncrEn;
        logic       DecrEn;
        logic [4:0] ShiftAmount;
    } norm_ctrl_t;

endpackage

// File: rtl/fp_add_sequencer_norm_decoder.sv
// ---------------------------------------------------------------------------
// norm_decoder
// Combinational mapping from the registered find-first-one index and the
// zero-sum flag to the normaliser controls.
//   Index : FFO position of the leading one in {carry,sum}
//   Zero  : sum was zero
//   Ctrl  : shift direction/amount and exponent adjust
// ---------------------------------------------------------------------------
module norm_decoder
    import floatingpointpkg::*;
#(
    parameter int MANT_MSB = floatingpointpkg::MANT_MSB
)(
    input  logic [4:0] Index,
    input  logic       Zero,
    output norm_ctrl_t Ctrl
);

    always_comb begin
        Ctrl = '0;
        if (Zero) begin
            // A zero sum has no leading one; leave the mantissa untouched.
            Ctrl.NoShift = 1'b1;
        end else if (Index == 5'(MANT_MSB + 1)) begin
            // Carry out of the add: one right shift, exponent +1.
            Ctrl.SREn   = 1'b1;
            Ctrl.IncrEn = 1'b1;
        end else if (Index == 5'(MANT_MSB)) begin
            Ctrl.NoShift = 1'b1;
        end else if (Index < 5'(MANT_MSB)) begin
            // Cancellation: bring the leading one up to the hidden-bit slot.
            Ctrl.SLEn        = 1'b1;
            Ctrl.DecrEn      = 1'b1;
            Ctrl.ShiftAmount = 5'(MANT_MSB) - Index;
        end else begin
            // Indices above the carry position cannot occur; stay inert.
            Ctrl.NoShift = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// ---------------------------------------------------------------------------
// fp_add_sequencer
// Control FSM for the single-precision floating-point adder datapath.
// A Go pulse in IDLE starts one operation: ALIGN -> NORM -> ROUND ->
// [RENORM] -> DONE -> IDLE. All outputs are decoded from the state and
// values captured at the Go edge (ExpSet/ExpDiff) and the ALIGN exit edge
// (zero sum).
//   Clock, Reset(active-low, async)
//   Go, ExpSet, ExpDiff       : start request and small-ALU results
//   FFOValid, Index           : find-first-one results
//   roundedMant               : rounding output, bit 24 = round overflow
//   SelExpMux/SelSRMuxL/G     : operand steering for alignment
//   ShiftRightEnable/Amount   : pre-add shifter
//   SREn/SLEn/ShiftAmount/NoShift/IncrEn/DecrEn : normaliser + exponent
//   SelMuxR                   : R1 feedback for post-round renormalise
//   Busy, ResultReady, ZeroResult : status
// ---------------------------------------------------------------------------
module fp_add_sequencer
    import floatingpointpkg::*;
#(
    parameter int SHIFT_W   = 6,
    parameter int SAT_SHIFT = floatingpointpkg::SAT_SHIFT,
    parameter int MANT_MSB  = floatingpointpkg::MANT_MSB
)(
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Go,
    input  logic               ExpSet,
    input  logic [7:0]         ExpDiff,
    input  logic               FFOValid,
    input  logic [4:0]         Index,
    input  logic [24:0]        roundedMant,
    output logic               SelExpMux,
    output logic               SelSRMuxL,
    output logic               SelSRMuxG,
    output logic               ShiftRightEnable,
    output logic [SHIFT_W-1:0] ShiftRightAmount,
    output logic               SREn,
    output logic               SLEn,
    output logic [4:0]         ShiftAmount,
    output logic               NoShift,
    output logic               IncrEn,
    output logic               DecrEn,
    output logic               SelMuxR,
    output logic               Busy,
    output logic               ResultReady,
    output logic               ZeroResult
);

    fp_add_state_t      stateReg;
    fp_add_state_t      stateNext;
    logic               expSetReg;
    logic [7:0]         expDiffReg;
    logic               zeroResultReg;
    logic [SHIFT_W-1:0] satAmount;
    norm_ctrl_t         normCtrl;

    // Only the overflow bit of the rounded mantissa steers control.
    logic unusedMantBits;
    assign unusedMantBits = ^roundedMant[23:0];

    // Differences past the saturation point shift every bit into sticky.
    assign satAmount = (expDiffReg > 8'(SAT_SHIFT)) ? SHIFT_W'(SAT_SHIFT)
                                                    : SHIFT_W'(expDiffReg);

    norm_decoder #(
        .MANT_MSB (MANT_MSB)
    ) uNormDecoder (
        .Index (Index),
        .Zero  (zeroResultReg),
        .Ctrl  (normCtrl)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateReg      <= IDLE;
            expSetReg     <= 1'b0;
            expDiffReg    <= '0;
            zeroResultReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == IDLE && Go) begin
                expSetReg  <= ExpSet;
                expDiffReg <= ExpDiff;
            end
            // R1 loads the sum on this same edge, so the zero flag lines up.
            if (stateReg == ALIGN) begin
                zeroResultReg <= ~FFOValid;
            end
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (Go) stateNext = ALIGN;
            ALIGN:   stateNext = NORM;
            NORM:    stateNext = ROUND;
            // A zero sum can never overflow in rounding; ignore bit 24 then.
            ROUND:   stateNext = (roundedMant[24] && !zeroResultReg) ? RENORM : DONE;
            RENORM:  stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        SelExpMux        = 1'b0;
        SelSRMuxL        = 1'b0;
        SelSRMuxG        = 1'b0;
        ShiftRightEnable = 1'b0;
        ShiftRightAmount = '0;
        SREn             = 1'b0;
        SLEn             = 1'b0;
        ShiftAmount      = '0;
        NoShift          = 1'b0;
        IncrEn           = 1'b0;
        DecrEn           = 1'b0;
        SelMuxR          = 1'b0;
        Busy             = 1'b0;
        ResultReady      = 1'b0;
        ZeroResult       = 1'b0;
        case (stateReg)
            ALIGN: begin
                Busy             = 1'b1;
                SelExpMux        = expSetReg;
                SelSRMuxG        = expSetReg;
                SelSRMuxL        = ~expSetReg;
                ShiftRightEnable = (expDiffReg != 8'd0);
                ShiftRightAmount = satAmount;
            end
            // Normaliser controls are held through ROUND so the rounder sees
            // the normalised mantissa.
            NORM, ROUND: begin
                Busy        = 1'b1;
                SREn        = normCtrl.SREn;
                SLEn        = normCtrl.SLEn;
                NoShift     = normCtrl.NoShift;
                IncrEn      = normCtrl.IncrEn;
                DecrEn      = normCtrl.DecrEn;
                ShiftAmount = normCtrl.ShiftAmount;
            end
            RENORM: begin
                Busy    = 1'b1;
                SelMuxR = 1'b1;
                SREn    = 1'b1;
                IncrEn  = 1'b1;
            end
            DONE: begin
                Busy        = 1'b1;
                ResultReady = 1'b1;
                ZeroResult  = zeroResultReg;
            end
            default: ;
        endcase
    end

endmodule
